contador_mod_updown: RTL and testbench

//  Parametrised synchronous up/down modulo counter; successor of the 4-bit 163-style counter.

---
 rtl/contador_mod_updown.sv | 73 +++++++
 tb/tb_contador_mod_updown.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/contador_mod_updown.sv
// Parametrised up/down modulo counter with load clamping, ENP/ENT enables and RCO.
// Optional compare flag (CMP input, registered MATCH output) when CONTADOR_MATCH_EN is defined.
module contador_mod_updown #(
    parameter int N        = 4,
    parameter int MODULO   = 16,
    parameter int SATURATE = 0
) (
    input  logic         CLK,
    input  logic         CLR_N,
    input  logic         SCLR,
    input  logic         LD,
    input  logic         ENP,
    input  logic         ENT,
    input  logic         UP,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic         RCO
`ifdef CONTADOR_MATCH_EN
    ,
    input  logic [N-1:0] CMP,
    output logic         MATCH
`endif
);

    // MODULO may equal 2**N, so the load range check needs one extra bit.
    localparam logic [N:0]   MOD_EXT = (N+1)'(MODULO);
    localparam logic [N-1:0] TERM    = N'(MODULO - 1);
    localparam logic         SAT     = (SATURATE != 0);

    logic [N-1:0] q_next;
    logic         is_term;
    logic         is_zero;
    logic         d_fits;

    assign is_term = (Q == TERM);
    assign is_zero = (Q == '0);
    assign d_fits  = ({1'b0, D} < MOD_EXT);

    assign RCO = ENT & (UP ? is_term : is_zero);

    always_comb begin
        // NOTE: default assignment first so no path leaves q_next unassigned (no latch).
        q_next = Q;
        if (SCLR) begin
            q_next = '0;
        end else if (!LD) begin
            q_next = d_fits ? D : TERM;
        end else if (ENT && ENP) begin
            if (UP) begin
                if (!is_term)  q_next = Q + N'(1);
                else if (!SAT) q_next = '0;
            end else begin
                if (!is_zero)  q_next = Q - N'(1);
                else if (!SAT) q_next = TERM;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) Q <= '0;
        else        Q <= q_next;
    end

`ifdef CONTADOR_MATCH_EN
    // Comparing against q_next makes MATCH a registered flag aligned with Q itself.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) MATCH <= 1'b0;
        else        MATCH <= (q_next == CMP);
    end
`endif

endmodule

// File: tb/tb_contador_mod_updown.sv
// Directed bench for contador_mod_updown: a wrapping and a saturating MODULO=10 instance.
// Compare-flag steps are compiled in only when CONTADOR_MATCH_EN is defined.
module tb_contador_mod_updown;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclr, ld, enp, ent, up;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;
    logic       s_sclr, s_ld, s_enp, s_ent, s_up;
    logic [3:0] s_d;
    logic [3:0] s_q;
    logic       s_rco;
`ifdef CONTADOR_MATCH_EN
    logic [3:0] cmp, s_cmp;
    logic       match, s_match;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    contador_mod_updown #(.N(4), .MODULO(10), .SATURATE(0)) dut (
        .CLK(clk), .CLR_N(rst_n), .SCLR(sclr), .LD(ld), .ENP(enp), .ENT(ent),
        .UP(up), .D(d), .Q(q), .RCO(rco)
`ifdef CONTADOR_MATCH_EN
        , .CMP(cmp), .MATCH(match)
`endif
    );

    contador_mod_updown #(.N(4), .MODULO(10), .SATURATE(1)) dut_s (
        .CLK(clk), .CLR_N(rst_n), .SCLR(s_sclr), .LD(s_ld), .ENP(s_enp), .ENT(s_ent),
        .UP(s_up), .D(s_d), .Q(s_q), .RCO(s_rco)
`ifdef CONTADOR_MATCH_EN
        , .CMP(s_cmp), .MATCH(s_match)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the rising edge, where inputs change and outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        sclr = 0; ld = 1; enp = 0; ent = 0; up = 1; d = 4'd0;
        s_sclr = 0; s_ld = 1; s_enp = 0; s_ent = 0; s_up = 1; s_d = 4'd0;
`ifdef CONTADOR_MATCH_EN
        cmp = 4'd4; s_cmp = 4'd15;
`endif
        #3;
        check("reset_q", q, 4'd0);
        check("reset_q_sat", s_q, 4'd0);
        check("reset_rco_ent0", rco, 1'b0);
`ifdef CONTADOR_MATCH_EN
        check("reset_match", match, 1'b0);
`endif
        // RCO is combinational and follows ENT/UP while reset is held.
        ent = 1; up = 0; #1;
        check("reset_rco_down", rco, 1'b1);
        up = 1; #1;
        check("reset_rco_up", rco, 1'b0);
        tick();
        check("reset_holds_over_edge", q, 4'd0);

        // T1: up-count through the wrap.
        @(negedge clk);
        rst_n = 1'b1; enp = 1; ent = 1; up = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("t1_q_%0d", k), q, 32'(k % 10));
            check($sformatf("t1_rco_%0d", k), rco, 32'((k % 10) == 9));
`ifdef CONTADOR_MATCH_EN
            check($sformatf("t6_match_%0d", k), match, 32'((k % 10) == 4));
`endif
        end

        // T2: sync clear, then down-count from 0 through the wrap.
        sclr = 1; tick(); sclr = 0;
        check("t2_sclr", q, 4'd0);
        up = 0; #1;
        check("t2_rco_at_0_down", rco, 1'b1);
        tick(); check("t2_q_9", q, 4'd9); check("t2_rco_9_down", rco, 1'b0);
        tick(); check("t2_q_8", q, 4'd8);
        tick(); check("t2_q_7", q, 4'd7);
        up = 1; #1;
        check("t2_rco_7_up", rco, 1'b0);

        // T4: load clamping and priorities.
        enp = 0; ent = 0;
        ld = 0; d = 4'd12; tick(); check("t4_clamp_12", q, 4'd9);
        d = 4'd10; sclr = 0; tick(); check("t4_clamp_10", q, 4'd9);
        d = 4'd5; sclr = 1; tick(); check("t4_sclr_beats_ld", q, 4'd0);
        sclr = 0; d = 4'd3; enp = 1; ent = 1; tick(); check("t4_ld_beats_count", q, 4'd3);
        d = 4'd9; tick(); check("t4_load_9", q, 4'd9);

        // T5: enables and RCO gating.
        d = 4'd7; enp = 0; ent = 0; tick(); check("t5_load_7", q, 4'd7);
        ld = 1; ent = 1; enp = 0; tick(); check("t5_enp0_hold", q, 4'd7);
        enp = 1; ent = 0; tick(); check("t5_ent0_hold", q, 4'd7);
        ld = 0; d = 4'd9; tick(); ld = 1;
        check("t5_rco_ent0", rco, 1'b0);
        ent = 1; enp = 0; #1;
        check("t5_rco_enp0", rco, 1'b1);
        enp = 1;
        tick(); check("t5_wrap_0", q, 4'd0);
        tick(); check("t5_q_1", q, 4'd1);
        tick(); check("t5_q_2", q, 4'd2);
        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1 check("t5_async_clr", q, 4'd0);
        check("t5_async_clr_sat", s_q, 4'd0);
        #2 rst_n = 1'b1;
        tick(); check("t5_restart_1", q, 4'd1);
        tick(); check("t5_restart_2", q, 4'd2);

`ifdef CONTADOR_MATCH_EN
        // T6: CMP outside the range never matches.
        cmp = 4'd11;
        for (int k = 0; k < 11; k++) begin
            tick();
            check($sformatf("t6_nomatch_%0d", k), match, 1'b0);
        end
`endif

        // T3: saturating instance holds at the terminal counts.
        s_ld = 0; s_d = 4'd8; tick(); s_ld = 1;
        check("t3_load_8", s_q, 4'd8);
        s_enp = 1; s_ent = 1; s_up = 1;
        tick(); check("t3_up_9a", s_q, 4'd9); check("t3_rco_a", s_rco, 1'b1);
        tick(); check("t3_up_9b", s_q, 4'd9); check("t3_rco_b", s_rco, 1'b1);
        tick(); check("t3_up_9c", s_q, 4'd9); check("t3_rco_c", s_rco, 1'b1);
        s_ld = 0; s_d = 4'd1; tick(); s_ld = 1; s_up = 0;
        check("t3_load_1", s_q, 4'd1);
        tick(); check("t3_dn_0a", s_q, 4'd0); check("t3_rco_dn", s_rco, 1'b1);
        tick(); check("t3_dn_0b", s_q, 4'd0);
        tick(); check("t3_dn_0c", s_q, 4'd0);
        s_ld = 0; s_d = 4'd15; tick(); s_ld = 1;
        check("t3_clamp_15", s_q, 4'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
